// File: rtl/dmem_arbiter_if.sv
// Bundle of every signal between the two requesters, the shared data memory
// and the arbiter. The arbiter binds to the slave modport. The requester and
// memory side (or a bench standing in for them) binds to the master modport.
//
// Handshake: a requester raises mX_req with mX_we/mX_addr/mX_wdata stable and
// keeps all of them unchanged until it sees mX_gnt high in the same cycle. The
// access is accepted on the rising edge where req & gnt are both high. Read
// data returns on mX_rvalid exactly one cycle after the accept edge. There is
// no backpressure on the return path.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Current port-1 starvation count, visible for checkers.
  logic [CNT_W-1:0]  dbg_wait_cnt;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    input  dbg_wait_cnt
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    output dbg_wait_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and DMA/debug
// (port 1). Port 0 has fixed priority. Port 1 is forced ahead after MAX_WAIT
// consecutive lost cycles. The memory has a registered read with 1-cycle
// latency, so the owner of each read is remembered for one cycle and the
// read data is routed back to that owner only.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic force1;
  logic gnt0;
  logic gnt1;
  logic mem_we_c;

  // Grants: port 1 wins when port 0 is idle or when port 1 has starved long
  // enough. Grants are held low during reset so that nothing is accepted.
  always_comb begin
    force1 = (wait_cnt_q >= CNT_W'(MAX_WAIT));
    gnt1   = rst_n & bus.m1_req & (force1 | ~bus.m0_req);
    gnt0   = rst_n & bus.m0_req & ~gnt1;
  end

  // Starvation counter: counts cycles where port 1 asks and loses, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.m1_req || gnt1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < CNT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Memory side mirrors the granted port. Address and write data hold their
  // previous value when idle, and the write enable is never raised without a grant.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_c    = 1'b0;
    if (gnt1) begin
      mem_addr_d  = bus.m1_addr;
      mem_wdata_d = bus.m1_wdata;
      mem_we_c    = bus.m1_we;
    end else if (gnt0) begin
      mem_addr_d  = bus.m0_addr;
      mem_wdata_d = bus.m0_wdata;
      mem_we_c    = bus.m0_we;
    end
  end

  // Read tracking: remember that a read was accepted, and by which port.
  always_comb begin
    rd_pend_d  = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
    rd_owner_d = rd_owner_q;
    if (rd_pend_d) begin
      rd_owner_d = gnt1;
    end
  end

  // State registers. An async reset drops any read that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Output drive: grants, memory side and routed read return.
  always_comb begin
    bus.m0_gnt       = gnt0;
    bus.m1_gnt       = gnt1;
    bus.mem_we       = mem_we_c;
    bus.mem_addr     = mem_addr_d;
    bus.mem_wdata    = mem_wdata_d;
    bus.m0_rvalid    = rd_pend_q & ~rd_owner_q;
    bus.m1_rvalid    = rd_pend_q & rd_owner_q;
    bus.m0_rdata     = (rd_pend_q & ~rd_owner_q) ? bus.mem_rdata : '0;
    bus.m1_rdata     = (rd_pend_q & rd_owner_q) ? bus.mem_rdata : '0;
    bus.dbg_wait_cnt = wait_cnt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. A word-addressed memory model sits on the memory
// side. A reference model predicts grants, the starvation count, the memory
// side signals and read returns, using a shadow copy of memory contents.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- memory model (word indexed by addr[9:2]) ----------------
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  // ---------------- reference model state ----------------
  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] exp_q [$];
  logic              own_q [$];
  int                m1_lost;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic              exp_g0, exp_g1;

  // requests as presented by the requesters this cycle
  logic              r0_req, r0_we, r1_req, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  // One bus cycle: check read return from the previous accept, drive the
  // requests, then check grants and the memory side against the model.
  task automatic cycle();
    logic              rv0, rv1, we;
    logic [DATA_W-1:0] rd0, rd1, wd;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
    if (own_q.size() > 0) begin
      logic              o;
      logic [DATA_W-1:0] d;
      o = own_q.pop_front();
      d = exp_q.pop_front();
      if (o) begin rv1 = 1'b1; rd1 = d; end
      else   begin rv0 = 1'b1; rd0 = d; end
    end
    chk("m0_rvalid", 64'(bus.m0_rvalid), 64'(rv0));
    chk("m1_rvalid", 64'(bus.m1_rvalid), 64'(rv1));
    chk("m0_rdata", 64'(bus.m0_rdata), 64'(rd0));
    chk("m1_rdata", 64'(bus.m1_rdata), 64'(rd1));

    bus.m0_req = r0_req; bus.m0_we = r0_we; bus.m0_addr = r0_addr; bus.m0_wdata = r0_wdata;
    bus.m1_req = r1_req; bus.m1_we = r1_we; bus.m1_addr = r1_addr; bus.m1_wdata = r1_wdata;
    #1;

    // Port 1 loses only if port 0 also asks and port 1 has lost fewer than
    // MAX_WAIT times in a row.
    exp_g1 = r1_req && !(r0_req && (m1_lost < MAX_WAIT));
    exp_g0 = r0_req && !exp_g1;
    chk("wait_cnt", 64'(bus.dbg_wait_cnt), 64'(m1_lost));
    chk("m0_gnt", 64'(bus.m0_gnt), 64'(exp_g0));
    chk("m1_gnt", 64'(bus.m1_gnt), 64'(exp_g1));

    we = 1'b0;
    if (exp_g0 || exp_g1) begin
      a  = exp_g1 ? r1_addr  : r0_addr;
      wd = exp_g1 ? r1_wdata : r0_wdata;
      we = exp_g1 ? r1_we    : r0_we;
      last_addr  = a;
      last_wdata = wd;
      if (we) ref_mem[a[9:2]] = wd;
      else begin
        exp_q.push_back(ref_mem[a[9:2]]);
        own_q.push_back(exp_g1);
      end
    end
    chk("mem_we", 64'(bus.mem_we), 64'(we));
    chk("mem_addr", 64'(bus.mem_addr), 64'(last_addr));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(last_wdata));

    if (!r1_req || exp_g1) m1_lost = 0;
    else if (m1_lost < MAX_WAIT) m1_lost = m1_lost + 1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    own_q.delete();
    m1_lost    = 0;
    last_addr  = '0;
    last_wdata = '0;
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] g1_hist;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    model_reset();

    // Reset held with both ports requesting: nothing is granted, outputs are quiet.
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h40; bus.m0_wdata = 32'h1234;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h44; bus.m1_wdata = 32'h5678;
    #2;
    chk("rst_m0_gnt", 64'(bus.m0_gnt), 64'd0);
    chk("rst_m1_gnt", 64'(bus.m1_gnt), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
    chk("rst_m1_rdata", 64'(bus.m1_rdata), 64'd0);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Port 0 write then read-back in the next cycle.
    set0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF); cycle();
    set0(1'b1, 1'b0, 32'h10, '0);           cycle();
    set0(1'b0, 1'b0, '0, '0);               cycle();
    cycle();

    // Async reset right after a port-0 read is accepted: the read is dropped.
    set0(1'b1, 1'b0, 32'h10, '0); cycle();
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    model_reset();
    #1;
    chk("midrd_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
    chk("midrd_mem_we", 64'(bus.mem_we), 64'd0);
    chk("midrd_wait_cnt", 64'(bus.dbg_wait_cnt), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycle();
    cycle();

    // Both ports request every cycle: port 1 gets every fifth slot.
    g1_hist = '0;
    for (int i = 0; i < 10; i++) begin
      set0(1'b1, 1'b0, 32'(i * 8), '0);
      set1(1'b1, 1'b0, 32'(i * 8 + 4), '0);
      cycle();
      g1_hist = {g1_hist[8:0], bus.m1_gnt};
    end
    chk("starve_pattern", 64'(g1_hist), 64'h021);
    set0(1'b0, 1'b0, '0, '0); set1(1'b0, 1'b0, '0, '0);
    cycle();
    cycle();

    // Interleaved reads by the two ports land on the right owner.
    set0(1'b1, 1'b1, 32'h0, 32'h1111_0000); cycle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b1, 1'b1, 32'h4, 32'h2222_0004); cycle();
    set1(1'b0, 1'b0, '0, '0);
    set0(1'b1, 1'b0, 32'h0, '0);            cycle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b1, 1'b0, 32'h4, '0);            cycle();
    set1(1'b0, 1'b0, '0, '0);               cycle();
    cycle();

    // Port 1 writes alone, port 0 reads it back.
    set1(1'b1, 1'b1, 32'h20, 32'hCAFEF00D); cycle();
    set1(1'b0, 1'b0, '0, '0);
    set0(1'b1, 1'b0, 32'h20, '0);           cycle();
    set0(1'b0, 1'b0, '0, '0);               cycle();
    cycle();

    // Random traffic. An ungranted request is held unchanged until granted.
    for (int n = 0; n < 400; n++) begin
      if (!(r0_req && !exp_g0)) begin
        if ($urandom_range(0, 9) < 7)
          set0(1'b1, 1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2), $urandom);
        else
          set0(1'b0, 1'b0, '0, '0);
      end
      if (!(r1_req && !exp_g1)) begin
        if ($urandom_range(0, 9) < 6)
          set1(1'b1, 1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2), $urandom);
        else
          set1(1'b0, 1'b0, '0, '0);
      end
      cycle();
    end
    set0(1'b0, 1'b0, '0, '0); set1(1'b0, 1'b0, '0, '0);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
